// File: rtl/lb_dispatch_if.sv
// lb_dispatch_if: metadata stream bundle around the dispatcher, holding both the
// parser-side sink and the region-side source. The dispatcher uses the slave view.
interface lb_dispatch_if #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2
);
  logic              meta_in_tvalid;
  logic              meta_in_tready;
  logic [DATA_W-1:0] meta_in_tdata;
  logic              meta_out_tvalid;
  logic              meta_out_tready;
  logic [DATA_W-1:0] meta_out_tdata;
  logic [DEST_W-1:0] meta_out_tdest;

  modport slave (
    input  meta_in_tvalid, meta_in_tdata,
    output meta_in_tready,
    output meta_out_tvalid, meta_out_tdata, meta_out_tdest,
    input  meta_out_tready
  );

  modport master (
    output meta_in_tvalid, meta_in_tdata,
    input  meta_in_tready,
    input  meta_out_tvalid, meta_out_tdata, meta_out_tdest,
    output meta_out_tready
  );
endinterface

// File: rtl/lb_dispatch.sv
// lb_dispatch: queues metadata beats and sends each to the least-loaded matching region,
// round-robin on ties. Define LB_RECONF_EN to raise a reconfiguration request on long misses.
module lb_dispatch #(
  parameter int HTTP_META_WIDTH   = 8,
  parameter int OPERATOR_ID_WIDTH = 2,
  parameter int N_REGIONS         = 4,
  parameter int LOAD_WIDTH        = 3,
  parameter int LOAD_MAX          = 4,
  parameter int QDEPTH            = 4,
  parameter int MISS_TIMEOUT      = 8,
  localparam int STAT_W = OPERATOR_ID_WIDTH + LOAD_WIDTH,
  localparam int IDX_W  = $clog2(N_REGIONS)
) (
  input  logic                          aclk,
  input  logic                          areset,
  lb_dispatch_if.slave                  meta,
  input  logic [N_REGIONS*STAT_W-1:0]   region_stats_in,
  output logic [IDX_W-1:0]              lb_ctrl,
  output logic                          pr_req,
  output logic [OPERATOR_ID_WIDTH-1:0]  pr_oid,
  output logic [IDX_W-1:0]              pr_region,
  input  logic                          pr_ack
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int MC_W  = $clog2(MISS_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SELECT, SEND, RECONF_WAIT} state_t;

  state_t state_q, state_d;

  logic [HTTP_META_WIDTH-1:0] fifo_mem [QDEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]             count_q, count_d;
  logic                       fifo_full, fifo_empty;
  logic                       push, pop;

  logic [HTTP_META_WIDTH-1:0]  hold_q, hold_d;
  logic [N_REGIONS*STAT_W-1:0] snap_q, snap_d;
  logic                        tvalid_q, tvalid_d;
  logic [IDX_W-1:0]            tdest_q, tdest_d;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [MC_W-1:0]             miss_cnt_q, miss_cnt_d;

  logic [OPERATOR_ID_WIDTH-1:0] req_oid;
  logic                         hit;
  logic [IDX_W-1:0]             hit_idx, rr_next;
  logic [LOAD_WIDTH-1:0]        hit_load, load_i;
  logic [OPERATOR_ID_WIDTH-1:0] oid_i;
  int                           scan_idx;

  assign fifo_full  = (count_q == (PTR_W+1)'(QDEPTH));
  assign fifo_empty = (count_q == '0);
  assign meta.meta_in_tready = !areset && !fifo_full;
  assign push = meta.meta_in_tvalid && meta.meta_in_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= meta.meta_in_tdata;
  end

  assign req_oid = hold_q[OPERATOR_ID_WIDTH-1:0];

  // Scan in round-robin order starting at rr_ptr; a strict less-than keeps the earliest tie.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_load = '0;
    oid_i    = '0;
    load_i   = '0;
    scan_idx = 0;
    for (int k = 0; k < N_REGIONS; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % N_REGIONS;
      {oid_i, load_i} = snap_q[scan_idx*STAT_W +: STAT_W];
      if (oid_i == req_oid && load_i < LOAD_WIDTH'(LOAD_MAX) &&
          (!hit || load_i < hit_load)) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(scan_idx);
        hit_load = load_i;
      end
    end
  end

  assign rr_next = (hit_idx == IDX_W'(N_REGIONS - 1)) ? '0 : hit_idx + IDX_W'(1);

`ifdef LB_RECONF_EN
  logic                         pr_req_q, pr_req_d;
  logic [OPERATOR_ID_WIDTH-1:0] pr_oid_q, pr_oid_d;
  logic [IDX_W-1:0]             pr_region_q, pr_region_d;
  logic [IDX_W-1:0]             least_idx;
  logic [LOAD_WIDTH-1:0]        least_load, least_li;
  int                           least_scan;

  // Reconfiguration target ignores operator and fullness: just the lightest region overall.
  always_comb begin
    least_idx  = '0;
    least_load = '0;
    least_li   = '0;
    least_scan = 0;
    for (int k = 0; k < N_REGIONS; k++) begin
      least_scan = (int'(rr_ptr_q) + k) % N_REGIONS;
      least_li   = snap_q[least_scan*STAT_W +: LOAD_WIDTH];
      if (k == 0 || least_li < least_load) begin
        least_idx  = IDX_W'(least_scan);
        least_load = least_li;
      end
    end
  end

  assign pr_req    = pr_req_q;
  assign pr_oid    = pr_oid_q;
  assign pr_region = pr_region_q;
`else
  logic unused_pr_ack;

  assign unused_pr_ack = pr_ack;
  assign pr_req    = 1'b0;
  assign pr_oid    = '0;
  assign pr_region = '0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    snap_d     = snap_q;
    tvalid_d   = tvalid_q;
    tdest_d    = tdest_q;
    rr_ptr_d   = rr_ptr_q;
    miss_cnt_d = miss_cnt_q;
    pop        = 1'b0;
`ifdef LB_RECONF_EN
    pr_req_d    = pr_req_q;
    pr_oid_d    = pr_oid_q;
    pr_region_d = pr_region_q;
`endif
    case (state_q)
      IDLE: begin
        miss_cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_mem[rd_ptr_q];
          snap_d  = region_stats_in;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (hit) begin
          tdest_d    = hit_idx;
          rr_ptr_d   = rr_next;
          tvalid_d   = 1'b1;
          miss_cnt_d = '0;
          state_d    = SEND;
        end else begin
          snap_d = region_stats_in;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + MC_W'(1);
`ifdef LB_RECONF_EN
          if (miss_cnt_d >= MC_W'(MISS_TIMEOUT)) begin
            pr_req_d    = 1'b1;
            pr_oid_d    = req_oid;
            pr_region_d = least_idx;
            state_d     = RECONF_WAIT;
          end
`endif
        end
      end
      SEND: begin
        if (meta.meta_out_tready) begin
          tvalid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = fifo_mem[rd_ptr_q];
            snap_d  = region_stats_in;
            state_d = SELECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RECONF_WAIT: begin
`ifdef LB_RECONF_EN
        // Fresh stats on ack so the new operator image can be picked up immediately.
        if (pr_ack) begin
          pr_req_d   = 1'b0;
          miss_cnt_d = '0;
          snap_d     = region_stats_in;
          state_d    = SELECT;
        end
`else
        state_d = SELECT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      snap_q     <= '0;
      tvalid_q   <= 1'b0;
      tdest_q    <= '0;
      rr_ptr_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_q     <= hold_d;
      snap_q     <= snap_d;
      tvalid_q   <= tvalid_d;
      tdest_q    <= tdest_d;
      rr_ptr_q   <= rr_ptr_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

`ifdef LB_RECONF_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pr_req_q    <= 1'b0;
      pr_oid_q    <= '0;
      pr_region_q <= '0;
    end else begin
      pr_req_q    <= pr_req_d;
      pr_oid_q    <= pr_oid_d;
      pr_region_q <= pr_region_d;
    end
  end
`endif

  assign meta.meta_out_tvalid = tvalid_q;
  assign meta.meta_out_tdata  = hold_q;
  assign meta.meta_out_tdest  = tdest_q;
  assign lb_ctrl              = tdest_q;

endmodule

// File: tb/tb_lb_dispatch.sv
// tb_lb_dispatch: directed and randomized stimulus for lb_dispatch, checked against a
// scoreboard filled by a least-load / round-robin reference model.
module tb_lb_dispatch;
  localparam int DW   = 8;
  localparam int OW   = 2;
  localparam int NR   = 4;
  localparam int LW   = 3;
  localparam int LMAX = 4;
  localparam int QD   = 4;
  localparam int MT   = 8;
  localparam int SW   = OW + LW;
  localparam int IW   = $clog2(NR);

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [NR*SW-1:0] region_stats = '0;
  logic [IW-1:0]  lb_ctrl;
  logic           pr_req;
  logic [OW-1:0]  pr_oid;
  logic [IW-1:0]  pr_region;
  logic           pr_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int mdl_rr = 0;
  int ready_mode = 0;
  logic [DW-1:0] exp_data[$];
  int            exp_dest[$];

  lb_dispatch_if #(.DATA_W(DW), .DEST_W(IW)) bus();

  lb_dispatch #(
    .HTTP_META_WIDTH(DW), .OPERATOR_ID_WIDTH(OW), .N_REGIONS(NR), .LOAD_WIDTH(LW),
    .LOAD_MAX(LMAX), .QDEPTH(QD), .MISS_TIMEOUT(MT)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .meta(bus),
    .region_stats_in(region_stats),
    .lb_ctrl(lb_ctrl),
    .pr_req(pr_req),
    .pr_oid(pr_oid),
    .pr_region(pr_region),
    .pr_ack(pr_ack)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: among eligible regions take the smallest (load, distance from rr) pair.
  function automatic int pickRegion(input logic [NR*SW-1:0] st, input int oid, input int rr,
                                    input bit any);
    int best = -1;
    int best_key = 0;
    for (int i = 0; i < NR; i++) begin
      int o = int'(st[i*SW+LW +: OW]);
      int l = int'(st[i*SW +: LW]);
      int key = l * NR + ((i - rr + NR) % NR);
      if ((any || (o == oid && l < LMAX)) && (best < 0 || key < best_key)) begin
        best = i;
        best_key = key;
      end
    end
    return best;
  endfunction

  task automatic setRegion(input int r, input int oid, input int load);
    region_stats[r*SW +: SW] = SW'(oid * (1 << LW) + load);
  endtask

  task automatic expectBeat(input logic [DW-1:0] data);
    int dest = pickRegion(region_stats, int'(data[OW-1:0]), mdl_rr, 1'b0);
    checkOutput("model_has_target", 32'(dest >= 0), 32'd1);
    if (dest >= 0) begin
      exp_data.push_back(data);
      exp_dest.push_back(dest);
      mdl_rr = (dest + 1) % NR;
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] data, input bit track);
    int waited = 0;
    bus.meta_in_tdata  = data;
    bus.meta_in_tvalid = 1'b1;
    @(negedge aclk);
    while (!bus.meta_in_tready && waited < 100) begin
      @(negedge aclk);
      waited++;
    end
    checkOutput("push_ready", 32'(bus.meta_in_tready), 32'd1);
    @(posedge aclk);
    #1;
    bus.meta_in_tvalid = 1'b0;
    if (track) expectBeat(data);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (exp_data.size() != 0 && n < 400) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("drain", 32'(exp_data.size()), 32'd0);
    exp_data.delete();
    exp_dest.delete();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bus.meta_out_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        0:       bus.meta_out_tready = 1'b0;
        1:       bus.meta_out_tready = 1'b1;
        default: bus.meta_out_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Whenever a beat is offered it must be the scoreboard head, held until taken.
  always @(negedge aclk) begin
    if (!areset && bus.meta_out_tvalid) begin
      checkOutput("beat_pending", 32'(exp_data.size() > 0), 32'd1);
      if (exp_data.size() > 0) begin
        checkOutput("out_tdata", 32'(bus.meta_out_tdata), 32'(exp_data[0]));
        checkOutput("out_tdest", 32'(bus.meta_out_tdest), 32'(exp_dest[0]));
        checkOutput("lb_ctrl", 32'(lb_ctrl), 32'(exp_dest[0]));
        if (bus.meta_out_tready) begin
          void'(exp_data.pop_front());
          void'(exp_dest.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] bp_vals[6];
    int servable[$];
    int accepted;
    int found;
    int nb;
    bit acc;

    bus.meta_in_tvalid = 1'b0;
    bus.meta_in_tdata  = '0;

    #2;
    checkOutput("rst_in_tready", 32'(bus.meta_in_tready), 32'd0);
    checkOutput("rst_tvalid", 32'(bus.meta_out_tvalid), 32'd0);
    checkOutput("rst_tdata", 32'(bus.meta_out_tdata), 32'd0);
    checkOutput("rst_tdest", 32'(bus.meta_out_tdest), 32'd0);
    checkOutput("rst_lb_ctrl", 32'(lb_ctrl), 32'd0);
    checkOutput("rst_pr_req", 32'(pr_req), 32'd0);
    checkOutput("rst_pr_oid", 32'(pr_oid), 32'd0);
    checkOutput("rst_pr_region", 32'(pr_region), 32'd0);
    #30;
    areset = 1'b0;
    #1;
    checkOutput("post_rst_in_tready", 32'(bus.meta_in_tready), 32'd1);

    // Hit with latency check
    @(posedge aclk); #1;
    ready_mode = 0;
    setRegion(0, 1, 2); setRegion(1, 1, 1); setRegion(2, 2, 0); setRegion(3, 3, 0);
    @(posedge aclk); #1;
    applyStimulus(8'h01, 1'b1);
    @(negedge aclk); checkOutput("hit_lat_c1", 32'(bus.meta_out_tvalid), 32'd0);
    @(negedge aclk); checkOutput("hit_lat_c2", 32'(bus.meta_out_tvalid), 32'd0);
    @(negedge aclk); checkOutput("hit_lat_c3", 32'(bus.meta_out_tvalid), 32'd1);
    checkOutput("hit_tdata", 32'(bus.meta_out_tdata), 32'h01);
    checkOutput("hit_tdest", 32'(bus.meta_out_tdest), 32'd1);
    checkOutput("hit_lb_ctrl", 32'(lb_ctrl), 32'd1);
    ready_mode = 1;
    waitDrain();

    // Equal loads rotate
    setRegion(0, 1, 1); setRegion(1, 1, 1); setRegion(2, 2, 0); setRegion(3, 2, 0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h01, 1'b1);
    waitDrain();

    // Full region is skipped even though it has the lower index
    setRegion(0, 1, 4); setRegion(1, 1, 3); setRegion(2, 2, 0); setRegion(3, 3, 0);
    applyStimulus(8'h05, 1'b1);
    waitDrain();

    // Backpressure: five beats fit (one held, four queued), the sixth is refused
    for (int r = 0; r < NR; r++) setRegion(r, r, 0);
    ready_mode = 0;
    @(posedge aclk); #1;
    bp_vals[0] = 8'hAA; bp_vals[1] = 8'hBB; bp_vals[2] = 8'hCC;
    bp_vals[3] = 8'hDD; bp_vals[4] = 8'hEE; bp_vals[5] = 8'hFF;
    accepted = 0;
    bus.meta_in_tdata  = bp_vals[0];
    bus.meta_in_tvalid = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      acc = bus.meta_in_tvalid && bus.meta_in_tready;
      @(posedge aclk); #1;
      if (acc) begin
        expectBeat(bus.meta_in_tdata);
        accepted++;
        if (accepted < 6) bus.meta_in_tdata = bp_vals[accepted];
        else bus.meta_in_tvalid = 1'b0;
      end
    end
    @(negedge aclk);
    checkOutput("bp_accepted", 32'(accepted), 32'd5);
    checkOutput("bp_in_tready", 32'(bus.meta_in_tready), 32'd0);
    checkOutput("bp_head_tdata", 32'(bus.meta_out_tdata), 32'hAA);
    bus.meta_in_tvalid = 1'b0;
    ready_mode = 1;
    waitDrain();

    // Miss: nothing serves operator 0
    setRegion(0, 1, 0); setRegion(1, 2, 1); setRegion(2, 3, 2); setRegion(3, 1, 3);
    applyStimulus(8'h00, 1'b0);
    repeat (12) @(negedge aclk);
    checkOutput("miss_no_tvalid", 32'(bus.meta_out_tvalid), 32'd0);
`ifdef LB_RECONF_EN
    checkOutput("miss_pr_req", 32'(pr_req), 32'd1);
    checkOutput("miss_pr_oid", 32'(pr_oid), 32'd0);
    checkOutput("miss_pr_region", 32'(pr_region), 32'(pickRegion(region_stats, 0, mdl_rr, 1'b1)));
    @(posedge aclk); #1;
    setRegion(2, 0, 0);
    expectBeat(8'h00);
    pr_ack = 1'b1;
    @(posedge aclk); #1;
    pr_ack = 1'b0;
    @(negedge aclk);
    checkOutput("pr_req_dropped", 32'(pr_req), 32'd0);
    waitDrain();
`else
    checkOutput("miss_no_pr_req", 32'(pr_req), 32'd0);
    @(posedge aclk); #1;
    setRegion(2, 0, 0);
    expectBeat(8'h00);
    found = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (bus.meta_out_tvalid) found = 1;
    end
    checkOutput("miss_recover", 32'(found), 32'd1);
    waitDrain();
`endif

    // Reset while a beat is held and another is queued
    for (int r = 0; r < NR; r++) setRegion(r, r, 0);
    ready_mode = 0;
    @(posedge aclk); #1;
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge aclk);
      if (bus.meta_out_tvalid) found = 1;
    end
    checkOutput("rst_pre_tvalid", 32'(found), 32'd1);
    #1;
    areset = 1'b1;
    exp_data.delete();
    exp_dest.delete();
    mdl_rr = 0;
    #1;
    checkOutput("rst_async_tvalid", 32'(bus.meta_out_tvalid), 32'd0);
    repeat (2) @(posedge aclk);
    #3;
    areset = 1'b0;
    ready_mode = 1;
    @(posedge aclk); #1;
    checkOutput("rst2_lb_ctrl", 32'(lb_ctrl), 32'd0);
    checkOutput("rst2_in_tready", 32'(bus.meta_in_tready), 32'd1);
    checkOutput("rst2_tvalid", 32'(bus.meta_out_tvalid), 32'd0);
    applyStimulus(8'h33, 1'b1);
    waitDrain();

    // Randomized traffic with random downstream backpressure
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NR; r++)
        setRegion(r, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      servable.delete();
      for (int o = 0; o < 4; o++)
        if (pickRegion(region_stats, o, 0, 1'b0) >= 0) servable.push_back(o);
      if (servable.size() == 0) begin
        setRegion(0, 0, 0);
        servable.push_back(0);
      end
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        logic [DW-1:0] d;
        d = DW'($urandom_range(0, 255));
        d[OW-1:0] = OW'(servable[$urandom_range(0, servable.size() - 1)]);
        applyStimulus(d, 1'b1);
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1;
      end
      waitDrain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_dispatch.md
# lb_dispatch

Parametrised successor to the single-queue load balancer. It buffers HTTP metadata beats in an input FIFO and dispatches each one to the best region. The best region is the least-loaded region whose loaded operator ID matches the request and which still has queue room; equal loads are broken by round-robin. It sits between the HTTP parser and the per-region operator queues, driving `lb_ctrl`/`meta_out_tdest`, and can optionally request partial reconfiguration when no region serves the requested operator.

## Interface
- `HTTP_META_WIDTH`, 8: metadata beat width; operator ID occupies `tdata[OPERATOR_ID_WIDTH-1:0]`.
- `OPERATOR_ID_WIDTH`, 2: operator ID width.
- `N_REGIONS`, 4: number of regions, ≥2.
- `LOAD_WIDTH`, 3: per-region load field width.
- `LOAD_MAX`, 4: region is full when load ≥ `LOAD_MAX`.
- `QDEPTH`, 4: input FIFO depth, power of two.
- `MISS_TIMEOUT`, 8: consecutive miss cycles before a PR request is raised (only with the configuration macro).

Ports:
- `aclk` in 1: clock.
- `areset` in 1: asynchronous, active-high reset.
- `meta_in_tvalid` in 1, `meta_in_tready` out 1, `meta_in_tdata` in `HTTP_META_WIDTH`: AXI4S sink.
- `region_stats_in` in `N_REGIONS*(OPERATOR_ID_WIDTH+LOAD_WIDTH)`: region i at `[i*W +: W]`, with `{oid, load}` (oid in the upper bits).
- `meta_out_tvalid` out 1, `meta_out_tready` in 1, `meta_out_tdata` out `HTTP_META_WIDTH`, `meta_out_tdest` out `$clog2(N_REGIONS)`: AXI4S source.
- `lb_ctrl` out `$clog2(N_REGIONS)`: last selected region; equals `meta_out_tdest`.
- `pr_req` out 1, `pr_oid` out `OPERATOR_ID_WIDTH`, `pr_region` out `$clog2(N_REGIONS)`, `pr_ack` in 1: reconfiguration handshake.

## Operation
- **Input FIFO:** `QDEPTH` entries; `meta_in_tready = !full`. Push on `tvalid&&tready`. Simultaneous push and pop when full is not allowed, because tready is already low.
- **FSM states:** IDLE, SELECT, SEND, RECONF_WAIT.
- **IDLE:** if the FIFO is not empty, pop the head into the hold register, register a snapshot of `region_stats_in`, and go to SELECT.
- **SELECT:**
  - Candidates are regions with `oid == hold[OPERATOR_ID_WIDTH-1:0]` and `load < LOAD_MAX`.
  - Pick the minimum load. On ties, pick the first index at or after `rr_ptr`, wrapping modulo `N_REGIONS`.
  - On a hit: register `tdest`/`lb_ctrl`, set `rr_ptr = sel+1` (wrapping), assert tvalid, go to SEND.
  - On a miss: re-snapshot the stats every cycle and stay in SELECT.
- **SEND:** hold `tdata` and `tdest` stable while `tvalid && !tready`. On handshake: go to SELECT if the FIFO is non-empty (pop and snapshot in the same cycle), otherwise go to IDLE.
- **Load comparison:** unsigned, `LOAD_WIDTH` bits; no arithmetic on loads.
- **Miss counter:** `$clog2(MISS_TIMEOUT)+1` bits; cleared on hit and in IDLE; saturates.
- **Reset values:**
  - `meta_in_tready=0` during reset, 1 after reset is released.
  - `meta_out_tvalid=0`, `meta_out_tdata=0`, `meta_out_tdest=0`, `lb_ctrl=0`.
  - `pr_req=0`, `pr_oid=0`, `pr_region=0`.
  - `rr_ptr=0`, FIFO empty, state IDLE.
- **Reset mid-operation:** any held or in-flight beat is discarded; `tvalid` and `pr_req` drop asynchronously.

## Timing
- Input handshake in cycle N leads to `meta_out_tvalid` high in cycle N+3 when the FIFO was empty: push, then IDLE pop, then SELECT registers the decision.
- Back-to-back dispatch: one beat every 2 cycles (SEND, then SELECT).
- The region stats used for a decision are those sampled one cycle before `tvalid` rises.
- `tdest` never changes while `tvalid` is high and `tready` is low.

## Configuration
- **`LB_RECONF_EN` defined:**
  - When the miss counter reaches `MISS_TIMEOUT`, assert `pr_req` with `pr_oid` = requested oid and `pr_region` = the least-loaded region overall (rr tie-break), then go to RECONF_WAIT.
  - `pr_req`, `pr_oid` and `pr_region` stay stable until `pr_ack` is sampled high. Then deassert `pr_req`, clear the miss counter, and return to SELECT.
  - Beats remain queued meanwhile.
- **Not defined:** `pr_req`, `pr_oid` and `pr_region` are tied to 0, `pr_ack` is ignored, and RECONF_WAIT is unreachable; a miss stalls in SELECT indefinitely.

## Test plan
All scenarios use defaults.
- **Hit:**
  - Stimulus: stats r0 `{1,2}`, r1 `{1,1}`, r2 `{2,0}`, r3 `{3,0}`; push `8'h01` in cycle N.
  - Response: `tvalid` at N+3 with `tdata=8'h01`, `tdest=1`, `lb_ctrl=1`.
- **Tie/round-robin:**
  - Stimulus: r0 `{1,1}`, r1 `{1,1}`, others `{2,0}`; push `8'h01` twice with `tready=1`.
  - Response: `tdest` 0 then 1; a third push gives 0.
- **Full region excluded:**
  - Stimulus: r0 `{1,4}`, r1 `{1,3}`; push `8'h05` (oid 1).
  - Response: `tdest=1`.
- **Backpressure:**
  - Stimulus: `tready=0` for 10 cycles; push `8'hAA`,`BB`,`CC`,`DD`,`EE`,`FF`.
  - Response: first beat held stable with unchanged `tdest`; after 5 accepted beats (4 FIFO entries plus 1 held), `meta_in_tready=0`. Releasing `tready` delivers `AA`..`EE` in order.
- **Miss:**
  - Stimulus: push `8'h00` with no oid-0 region.
  - Response without macro: no `tvalid`; setting r2 to `{0,0}` yields `tdest=2` within 2 cycles.
  - Response with `LB_RECONF_EN`: `pr_req=1` after 8 miss cycles, with `pr_oid=0` and `pr_region` = least-loaded index. `pr_ack` plus stats update gives dispatch.
- **Reset mid-SEND:**
  - Stimulus: assert `areset` while `tvalid=1`.
  - Response: `tvalid` falls immediately. After release the FIFO is empty, `lb_ctrl=0`, and the next push dispatches normally.
